prng_share_ctrl: RTL and testbench



---
 rtl/prng_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 29 ++
 rtl/prng_share_ctrl.sv | 126 ++++++++++++
 tb/tb_prng_share_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and helpers for the dither PRNG share controller.
// Holds the controller state encoding, default PRNG width and the round-robin pick.
// Pure declarations; no clocked logic lives here.
package prng_pkg;

  typedef enum logic [2:0] {
    WARMUP = 3'd0,
    READY  = 3'd1,
    STEP   = 3'd2,
    CAPT   = 3'd3,
    ACK    = 3'd4
  } state_e;

  localparam int unsigned DEF_NUM_PRND_BITS = 9;

  // Widest requester vector the pick function handles; narrower callers zero-extend.
  localparam int unsigned MAX_REQ = 8;

  // Index of the first set request at or after ptr, wrapping modulo num_req.
  // Returns ptr when nothing is set; callers qualify the result with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req_v,
                                         input logic [2:0]         ptr,
                                         input int unsigned        num_req);
    logic [2:0]  idx;
    logic        found;
    int unsigned cand;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      // ptr < num_req and i < num_req, so one subtraction performs the wrap.
      cand = 32'(ptr) + i;
      if (cand >= num_req) begin
        cand = cand - num_req;
      end
      if (!found && (i < num_req) && req_v[3'(cand)]) begin
        idx   = 3'(cand);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick: first set request at or after the pointer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               found_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;

  // Widen request and pointer to the fixed width the shared pick function expects.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_i;
    ptr_ext              = '0;
    ptr_ext[IW-1:0]      = ptr_i;
    idx_o                = IW'(rr_pick(req_ext, ptr_ext, NUM_REQ));
    found_o              = |req_i;
  end

endmodule

// File: rtl/prng_share_ctrl.sv
// Owns the shared dither PRNG enable: warm-up burst, then one PRNG step per round-robin grant.
// Latency: ack (with rsp_data) three cycles after req is sampled in READY; four-cycle service period.
// Backpressure: requesters hold req until their ack bit; worst-case wait NUM_REQ*4 cycles.
module prng_share_ctrl
  import prng_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned NUM_PRND_BITS = DEF_NUM_PRND_BITS,
  parameter int unsigned WARMUP_CYCLES = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     restart,
  input  logic                     free_run,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_PRND_BITS-1:0] prnd_num,
  output logic                     prng_en,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_PRND_BITS-1:0] rsp_data,
  output logic                     ready
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = 8;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     prng_en_q, prng_en_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [NUM_PRND_BITS-1:0] rsp_q, rsp_d;

  logic [IW-1:0]            arb_idx;
  logic                     arb_found;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  // State, counters and all outputs are registered; reset kills any in-flight ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= WARMUP;
      cnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      prng_en_q <= 1'b0;
      ack_q     <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      prng_en_q <= prng_en_d;
      ack_q     <= ack_d;
      rsp_q     <= rsp_d;
    end
  end

  // Next state and next registered outputs; restart overrides every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    prng_en_d = 1'b0;
    ack_d     = '0;
    rsp_d     = rsp_q;
    if (restart) begin
      // Behaves like a reset release: an aborted grant never acks, the pointer survives.
      state_d = WARMUP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WARMUP: begin
          if (cnt_q == CW'(WARMUP_CYCLES)) begin
            state_d = READY;
          end else begin
            prng_en_d = 1'b1;
            cnt_d     = cnt_q + CW'(1);
          end
        end
        READY: begin
          if (arb_found) begin
            idx_d     = arb_idx;
            prng_en_d = 1'b1;
            state_d   = STEP;
          end else begin
            prng_en_d = free_run;
          end
        end
        STEP: begin
          // prng_en is high this cycle, so the PRNG holds a fresh value in CAPT.
          state_d = CAPT;
        end
        CAPT: begin
          rsp_d   = prnd_num;
          ack_d   = NUM_REQ'(1) << idx_q;
          ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
          state_d = ACK;
        end
        ACK: begin
          // req is not looked at here; a req still high next cycle is a new request.
          state_d = READY;
        end
        default: begin
          state_d = WARMUP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign prng_en  = prng_en_q;
  assign ack      = ack_q;
  assign rsp_data = rsp_q;
  assign ready    = (state_q != WARMUP);

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Directed bench for prng_share_ctrl with a local 16-bit LFSR standing in for the PRNG.
module tb_prng_share_ctrl;

  localparam int NR = 4;
  localparam int PB = 9;
  localparam int WU = 32;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          restart  = 1'b0;
  logic          free_run = 1'b0;
  logic [NR-1:0] req      = '0;
  logic [PB-1:0] prnd_num;
  logic          prng_en;
  logic [NR-1:0] ack;
  logic [PB-1:0] rsp_data;
  logic          ready;

  logic [15:0]   lfsr = 16'hACE1;
  logic [PB-1:0] exp_rsp;
  int            checks = 0;
  int            fails  = 0;

  prng_share_ctrl #(
    .NUM_REQ       (NR),
    .NUM_PRND_BITS (PB),
    .WARMUP_CYCLES (WU)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .restart  (restart),
    .free_run (free_run),
    .req      (req),
    .prnd_num (prnd_num),
    .prng_en  (prng_en),
    .ack      (ack),
    .rsp_data (rsp_data),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  // Stand-in PRNG: advances once per clock while enabled.
  always @(posedge clock) begin
    if (prng_en === 1'b1) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign prnd_num = lfsr[PB-1:0];

  // Walks one warm-up burst; entered on the negedge where warm-up begins counting.
  task automatic check_warmup(input string tag);
    for (int k = 1; k <= WU + 1; k++) begin
      @(negedge clock);
      checks++;
      if (prng_en !== (k <= WU)) begin
        fails++;
        $display("FAIL %s_prng_en cycle %0d: got %b expected %b", tag, k, prng_en, (k <= WU));
      end
      checks++;
      if (ready !== (k == WU + 1)) begin
        fails++;
        $display("FAIL %s_ready cycle %0d: got %b expected %b", tag, k, ready, (k == WU + 1));
      end
      checks++;
      if (ack !== '0) begin
        fails++;
        $display("FAIL %s_ack cycle %0d: got %b expected 0000", tag, k, ack);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({prng_en, ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_en_ready: got %b expected 00", {prng_en, ready});
    end
    checks++;
    if ({ack, rsp_data} !== '0) begin
      fails++;
      $display("FAIL reset_ack_rsp: got ack=%b rsp=%h expected 0/0", ack, rsp_data);
    end
    reset = 1'b1;
    check_warmup("warmup");
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_ack;
    int            wait_n;
    req     = 4'b1111;
    exp_ack = 4'b0001;
    wait_n  = 3;
    for (int g = 0; g < 5; g++) begin
      for (int c = 1; c <= wait_n; c++) begin
        @(negedge clock);
        checks++;
        if (c < wait_n && ack !== '0) begin
          fails++;
          $display("FAIL rr_idle grant %0d cycle %0d: got %b expected 0000", g, c, ack);
        end else if (c == wait_n && ack !== exp_ack) begin
          fails++;
          $display("FAIL rr_ack grant %0d: got %b expected %b", g, ack, exp_ack);
        end
      end
      req     = req & ~exp_ack;
      exp_ack = (exp_ack == 4'b1000) ? 4'b0001 : exp_ack << 1;
      wait_n  = 4;
      // Re-raise all four after the last one is served: the pointer must wrap to 0.
      if (g == 3) req = 4'b1111;
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_single();
    req = 4'b0100;
    @(negedge clock);
    checks++;
    if (prng_en !== 1'b1 || ack !== '0) begin
      fails++;
      $display("FAIL single_step: got en=%b ack=%b expected 1/0000", prng_en, ack);
    end
    @(negedge clock);
    checks++;
    if (prng_en !== 1'b0) begin
      fails++;
      $display("FAIL single_capt_en: got %b expected 0", prng_en);
    end
    exp_rsp = prnd_num;
    @(negedge clock);
    checks++;
    if (ack !== 4'b0100) begin
      fails++;
      $display("FAIL single_ack: got %b expected 0100", ack);
    end
    checks++;
    if (rsp_data !== exp_rsp) begin
      fails++;
      $display("FAIL single_rsp: got %h expected %h", rsp_data, exp_rsp);
    end
    req = '0;
    @(negedge clock);
    checks++;
    if (ack !== '0 || ready !== 1'b1 || rsp_data !== exp_rsp) begin
      fails++;
      $display("FAIL single_after: got ack=%b rdy=%b rsp=%h expected 0000/1/%h", ack, ready, rsp_data, exp_rsp);
    end
  endtask

  task automatic test_free_run();
    free_run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++;
      if (prng_en !== 1'b1 || rsp_data !== exp_rsp) begin
        fails++;
        $display("FAIL free_run cycle %0d: got en=%b rsp=%h expected 1/%h", k, prng_en, rsp_data, exp_rsp);
      end
    end
    req = 4'b0001;
    repeat (2) @(negedge clock);
    checks++;
    if (ack !== '0) begin
      fails++;
      $display("FAIL free_run_early_ack: got %b expected 0000", ack);
    end
    exp_rsp = prnd_num;
    @(negedge clock);
    checks++;
    if (ack !== 4'b0001 || rsp_data !== exp_rsp) begin
      fails++;
      $display("FAIL free_run_grant: got ack=%b rsp=%h expected 0001/%h", ack, rsp_data, exp_rsp);
    end
    req      = '0;
    free_run = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    @(negedge clock);
    checks++;
    if (prng_en !== 1'b1) begin
      fails++;
      $display("FAIL mid_step_en: got %b expected 1", prng_en);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ack, prng_en, ready} !== '0) begin
      fails++;
      $display("FAIL mid_reset_now: got ack=%b en=%b rdy=%b expected 0", ack, prng_en, ready);
    end
    @(negedge clock);
    reset = 1'b1;
    check_warmup("mid_warmup");
    // req has stayed high throughout; pointer restarted at 0 so requester 1 wins.
    repeat (3) @(negedge clock);
    checks++;
    if (ack !== 4'b0010) begin
      fails++;
      $display("FAIL mid_served: got %b expected 0010", ack);
    end
    req = '0;
    @(negedge clock);
  endtask

  task automatic test_restart();
    // Pointer is 2 here: 1010 picks requester 3. A lost pointer would pick requester 1.
    req = 4'b1010;
    repeat (2) @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    checks++;
    if ({ack, ready, prng_en} !== '0) begin
      fails++;
      $display("FAIL restart_abort: got ack=%b rdy=%b en=%b expected 0", ack, ready, prng_en);
    end
    check_warmup("restart_warmup");
    repeat (3) @(negedge clock);
    checks++;
    if (ack !== 4'b1000) begin
      fails++;
      $display("FAIL restart_served: got %b expected 1000", ack);
    end
    req = '0;
    @(negedge clock);
    checks++;
    if (ack !== '0) begin
      fails++;
      $display("FAIL restart_ack_drop: got %b expected 0000", ack);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_free_run();
    test_reset_mid();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
